// File: rtl/cavlc_level_dec.sv
// -----------------------------------------------------------------------------
// cavlc_level_dec
//
// Purpose:
//   Decodes CAVLC coefficient levels for one H.264 4x4/2x2 residual block.
//   It is started with TotalCoeff/TrailingOnes from the coeff_token stage.
//   It first reads the trailing-one sign bits. It then reads a level_prefix
//   and an optional level_suffix for each remaining coefficient, and adapts
//   suffixLength after each such level. Signed levels are emitted in
//   bitstream order.
//
// Ports:
//   Clk, nReset            clock, asynchronous active-low reset
//   Start                  one-cycle block start (ignored while Busy)
//   TotalCoeff[CW]         coefficients in the block, sampled on Start
//   TrailingOnes[2]        trailing +/-1 count, sampled on Start
//   Window[WIN_W]          next stream bits, MSB is the next bit
//   WinValid               Window holds at least WIN_W valid bits
//   ShiftEn / ShiftBits    combinational consume request. The source drops
//                          ShiftBits bits at the same clock edge.
//   LevelOut[LEVEL_W]      signed level
//   WrReq / LevelReady     level handshake (see below)
//   BlockDone              one-cycle pulse, block complete
//   Error                  one-cycle pulse, block rejected or aborted
//   Busy                   decoder not idle
//   DbgState[3]            current FSM state, for checkers
//
// Handshake: WrReq is a valid flag. Once raised, it and LevelOut stay
//   unchanged until a cycle with WrReq & LevelReady, which is the single
//   transfer cycle for that level. WrReq never waits on LevelReady.
//
// Build option:
//   CAVLC_LEVEL_SAT_EN  When defined, levels outside +/-(2^(LEVEL_W-1)-1)
//                       saturate to that bound. When not defined, levels
//                       keep only their low LEVEL_W bits (two's-complement
//                       wrap).
// -----------------------------------------------------------------------------
module cavlc_level_dec #(
  parameter int WIN_W     = 16,
  parameter int LEVEL_W   = 13,
  parameter int MAX_COEFF = 16,
  localparam int CW       = $clog2(MAX_COEFF + 1),
  localparam int SBW      = $clog2(WIN_W + 1)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic [CW-1:0]      TotalCoeff,
  input  logic [1:0]         TrailingOnes,
  input  logic [WIN_W-1:0]   Window,
  input  logic               WinValid,
  output logic               ShiftEn,
  output logic [SBW-1:0]     ShiftBits,
  output logic [LEVEL_W-1:0] LevelOut,
  output logic               WrReq,
  input  logic               LevelReady,
  output logic               BlockDone,
  output logic               Error,
  output logic               Busy,
  output logic [2:0]         DbgState
);

  // Full-width signed level. It is wide enough for the 14-bit level math
  // and for LEVEL_W.
  localparam int FW = (LEVEL_W > 15) ? LEVEL_W : 15;
  localparam logic signed [FW-1:0] LVL_MAX = FW'((longint'(1) << (LEVEL_W - 1)) - 1);
  localparam logic signed [FW-1:0] LVL_MIN = -LVL_MAX;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T1     = 3'd1,
    PREFIX = 3'd2,
    SUFFIX = 3'd3,
    OUT    = 3'd4,
    DONE   = 3'd5
  } stateT;

  stateT        state, stateNext;
  logic [CW-1:0] tcReg, tcNext;
  logic [1:0]   t1Reg, t1Next;
  logic [CW-1:0] idx, idxNext;
  logic [2:0]   sufLen, sufLenNext;
  logic [3:0]   prefixReg, prefixNext;
  logic [3:0]   sufSize, sufSizeNext;
  logic [LEVEL_W-1:0] levelNext;
  logic         wrReqNext;
  logic         errNext;

  // ---------------------------------------------------------------------------
  // Bit-window decode
  // ---------------------------------------------------------------------------
  logic [15:0]      top16;
  logic [4:0]       lz;
  logic             allZero;
  logic [3:0]       prefixSufSize;
  logic [WIN_W-1:0] winShift;
  logic [11:0]      sufVal;

  assign top16   = Window[WIN_W-1 -: 16];
  assign allZero = (top16 == 16'd0);

  // Leading-zero count. The scan goes from the LSB, so the highest set bit
  // is the last one to write lz and decides the result.
  always_comb begin
    lz = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (top16[i]) lz = 5'(15 - i);
    end
  end

  // Prefix 14 with suffixLength 0 uses a 4-bit escape suffix. Prefix 15
  // always uses 12 bits.
  always_comb begin
    if (lz == 5'd14 && sufLen == 3'd0)  prefixSufSize = 4'd4;
    else if (lz == 5'd15)               prefixSufSize = 4'd12;
    else                                prefixSufSize = {1'b0, sufLen};
  end

  // level_suffix is the top sufSize bits of the window, read in SUFFIX.
  assign winShift = Window >> (WIN_W - int'(sufSize));
  assign sufVal   = winShift[11:0];

  // ---------------------------------------------------------------------------
  // Level arithmetic
  // ---------------------------------------------------------------------------
  logic [3:0]             pfx;
  logic [11:0]            sfx;
  logic [13:0]            levelCode;
  logic [13:0]            levelMag;
  logic signed [FW-1:0]   levelFull;
  logic [LEVEL_W-1:0]     levelNarrow;
  logic [LEVEL_W-1:0]     t1Level;
  logic [2:0]             sl1;
  logic [13:0]            thr;
  logic [2:0]             sufLenUpd;

  always_comb begin
    // In PREFIX the level is finished with no suffix bits. In SUFFIX the
    // stored prefix is combined with the suffix bits now in the window.
    pfx = (state == SUFFIX) ? prefixReg : lz[3:0];
    sfx = (state == SUFFIX) ? sufVal : 12'd0;
    levelCode = (14'(pfx) << sufLen) + 14'(sfx);
    if (pfx == 4'd15 && sufLen == 3'd0) levelCode = levelCode + 14'd15;
    // The first non-T1 level cannot be +/-1 when fewer than 3 trailing ones
    // were coded, so its code is offset by 2.
    if (idx == CW'(t1Reg) && t1Reg != 2'd3) levelCode = levelCode + 14'd2;
    levelMag  = levelCode[0] ? ((levelCode + 14'd1) >> 1) : ((levelCode + 14'd2) >> 1);
    levelFull = levelCode[0] ? -$signed(FW'(levelMag)) : $signed(FW'(levelMag));
`ifdef CAVLC_LEVEL_SAT_EN
    if (levelFull > LVL_MAX)      levelNarrow = LVL_MAX[LEVEL_W-1:0];
    else if (levelFull < LVL_MIN) levelNarrow = LVL_MIN[LEVEL_W-1:0];
    else                          levelNarrow = levelFull[LEVEL_W-1:0];
`else
    levelNarrow = levelFull[LEVEL_W-1:0];
`endif
    // Adaptation uses the full-width magnitude, not the narrowed output.
    sl1       = (sufLen == 3'd0) ? 3'd1 : sufLen;
    thr       = 14'd3 << (sl1 - 3'd1);
    sufLenUpd = (levelMag > thr && sl1 < 3'd6) ? sl1 + 3'd1 : sl1;
    t1Level   = Window[WIN_W-1] ? '1 : LEVEL_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Consume request (combinational, one request per cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    ShiftEn   = 1'b0;
    ShiftBits = '0;
    if (WinValid) begin
      case (state)
        T1: begin
          ShiftEn   = 1'b1;
          ShiftBits = SBW'(1);
        end
        PREFIX: begin
          if (!allZero) begin
            ShiftEn   = 1'b1;
            ShiftBits = SBW'(lz) + SBW'(1);
          end
        end
        SUFFIX: begin
          ShiftEn   = 1'b1;
          ShiftBits = SBW'(sufSize);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext   = state;
    tcNext      = tcReg;
    t1Next      = t1Reg;
    idxNext     = idx;
    sufLenNext  = sufLen;
    prefixNext  = prefixReg;
    sufSizeNext = sufSize;
    levelNext   = LevelOut;
    wrReqNext   = WrReq;
    errNext     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (int'(TotalCoeff) > MAX_COEFF || int'(TrailingOnes) > int'(TotalCoeff)) begin
            errNext = 1'b1;
          end else if (TotalCoeff == '0) begin
            stateNext = DONE;
          end else begin
            tcNext     = TotalCoeff;
            t1Next     = TrailingOnes;
            idxNext    = '0;
            sufLenNext = (int'(TotalCoeff) > 10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
            stateNext  = (TrailingOnes != 2'd0) ? T1 : PREFIX;
          end
        end
      end
      T1: begin
        if (WinValid) begin
          levelNext = t1Level;
          wrReqNext = 1'b1;
          stateNext = OUT;
        end
      end
      PREFIX: begin
        if (WinValid) begin
          if (allZero) begin
            errNext   = 1'b1;
            stateNext = IDLE;
          end else begin
            prefixNext  = lz[3:0];
            sufSizeNext = prefixSufSize;
            if (prefixSufSize == 4'd0) begin
              levelNext  = levelNarrow;
              sufLenNext = sufLenUpd;
              wrReqNext  = 1'b1;
              stateNext  = OUT;
            end else begin
              stateNext = SUFFIX;
            end
          end
        end
      end
      SUFFIX: begin
        if (WinValid) begin
          levelNext  = levelNarrow;
          sufLenNext = sufLenUpd;
          wrReqNext  = 1'b1;
          stateNext  = OUT;
        end
      end
      OUT: begin
        if (LevelReady) begin
          wrReqNext = 1'b0;
          idxNext   = idx + CW'(1);
          if (idx + CW'(1) == tcReg)            stateNext = DONE;
          else if (idx + CW'(1) < CW'(t1Reg))   stateNext = T1;
          else                                  stateNext = PREFIX;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      tcReg     <= '0;
      t1Reg     <= '0;
      idx       <= '0;
      sufLen    <= '0;
      prefixReg <= '0;
      sufSize   <= '0;
      LevelOut  <= '0;
      WrReq     <= 1'b0;
      BlockDone <= 1'b0;
      Error     <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      tcReg     <= tcNext;
      t1Reg     <= t1Next;
      idx       <= idxNext;
      sufLen    <= sufLenNext;
      prefixReg <= prefixNext;
      sufSize   <= sufSizeNext;
      LevelOut  <= levelNext;
      WrReq     <= wrReqNext;
      BlockDone <= (stateNext == DONE);
      Error     <= errNext;
      Busy      <= (stateNext != IDLE);
    end
  end

  assign DbgState = state;

endmodule

// File: tb/tb_cavlc_level_dec.sv
// -----------------------------------------------------------------------------
// tb_cavlc_level_dec
//
// Directed bench for cavlc_level_dec, built with LEVEL_W = 8 so that level
// narrowing can be exercised. The bench keeps the bitstream as a 128-bit
// vector plus a read pointer. It samples the DUT at the falling edge and
// advances the pointer just after the rising edge.
// -----------------------------------------------------------------------------
module tb_cavlc_level_dec;

  localparam int WIN_W     = 16;
  localparam int LEVEL_W   = 8;
  localparam int MAX_COEFF = 16;
  localparam int CW        = 5;
  localparam int SBW       = 5;

  // ---------------------------------------------------------------- clock/reset
  logic               Clk = 1'b0;
  logic               nReset = 1'b0;
  logic               Start = 1'b0;
  logic [CW-1:0]      TotalCoeff = '0;
  logic [1:0]         TrailingOnes = '0;
  logic [WIN_W-1:0]   Window;
  logic               WinValid = 1'b0;
  logic               ShiftEn;
  logic [SBW-1:0]     ShiftBits;
  logic [LEVEL_W-1:0] LevelOut;
  logic               WrReq;
  logic               LevelReady = 1'b1;
  logic               BlockDone;
  logic               Error;
  logic               Busy;
  logic [2:0]         DbgState;

  always #5 Clk = ~Clk;

  cavlc_level_dec #(
    .WIN_W(WIN_W),
    .LEVEL_W(LEVEL_W),
    .MAX_COEFF(MAX_COEFF)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .Start(Start),
    .TotalCoeff(TotalCoeff),
    .TrailingOnes(TrailingOnes),
    .Window(Window),
    .WinValid(WinValid),
    .ShiftEn(ShiftEn),
    .ShiftBits(ShiftBits),
    .LevelOut(LevelOut),
    .WrReq(WrReq),
    .LevelReady(LevelReady),
    .BlockDone(BlockDone),
    .Error(Error),
    .Busy(Busy),
    .DbgState(DbgState)
  );

  // ---------------------------------------------------------------- stream model
  logic [127:0] strm = '0;
  int           ptr = 0;

  always_comb begin : winGen
    logic [127:0] sh;
    sh = strm << ptr;
    Window = sh[127:112];
  end

  // ---------------------------------------------------------------- scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];
  logic [31:0] expShQ[$];
  logic [31:0] shiftQ[$];
  int          doneCnt = 0;
  int          errCnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    logic           se;
    logic [SBW-1:0] sb;
    @(negedge Clk);
    se = ShiftEn;
    sb = ShiftBits;
    if (se) shiftQ.push_back(32'(sb));
    if (WrReq && LevelReady) gotQ.push_back(32'($signed(LevelOut)));
    if (BlockDone) doneCnt++;
    if (Error) errCnt++;
    @(posedge Clk);
    #1;
    if (se) ptr += int'(sb);
  endtask

  task automatic loadStream(input logic [127:0] s);
    strm = s;
    ptr = 0;
    expQ.delete();
    gotQ.delete();
    expShQ.delete();
    shiftQ.delete();
    doneCnt = 0;
    errCnt = 0;
  endtask

  task automatic startBlock(input int tc, input int t1);
    TotalCoeff = CW'(tc);
    TrailingOnes = 2'(t1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic waitEnd(input string tag, input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && errCnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_ended"}, 32'(n < budget), 32'd1);
  endtask

  task automatic compareAll(input string tag);
    check({tag, "_nlev"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      check($sformatf("%s_lev%0d", tag, i), gotQ[i], expQ[i]);
    check({tag, "_nshift"}, 32'(shiftQ.size()), 32'(expShQ.size()));
    for (int i = 0; i < expShQ.size() && i < shiftQ.size(); i++)
      check($sformatf("%s_sh%0d", tag, i), shiftQ[i], expShQ[i]);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_shen"}, 32'(ShiftEn), 32'd0);
    check({tag, "_shbits"}, 32'(ShiftBits), 32'd0);
    check({tag, "_level"}, 32'(LevelOut), 32'd0);
    check({tag, "_wrreq"}, 32'(WrReq), 32'd0);
    check({tag, "_done"}, 32'(BlockDone), 32'd0);
    check({tag, "_err"}, 32'(Error), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset values
    #1;
    checkIdleOutputs("rst");
    tick();
    tick();
    nReset = 1'b1;
    tick();

    // Empty block; a second Start during the BlockDone cycle is ignored
    loadStream('0);
    WinValid = 1'b1;
    startBlock(0, 0);
    check("tc0_done", 32'(BlockDone), 32'd1);
    check("tc0_busy", 32'(Busy), 32'd1);
    check("tc0_shen", 32'(ShiftEn), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("tc0_ign_busy", 32'(Busy), 32'd0);
    tick();
    tick();
    check("tc0_ndone", 32'(doneCnt), 32'd1);
    compareAll("tc0");

    // Trailing ones: bits 0,1,0 give +1,-1,+1
    loadStream({3'b010, 125'b0});
    startBlock(3, 3);
    check("t1_first_shen", 32'(ShiftEn), 32'd1);
    check("t1_first_shbits", 32'(ShiftBits), 32'd1);
    waitEnd("t1", 40);
    expQ = '{32'd1, 32'hFFFF_FFFF, 32'd1};
    expShQ = '{32'd1, 32'd1, 32'd1};
    compareAll("t1");
    check("t1_ndone", 32'(doneCnt), 32'd1);

    // Mixed: T1 bit '1' -> -1, then prefix 0 with +2 bias -> +2
    loadStream({2'b11, 126'b0});
    startBlock(2, 1);
    waitEnd("mix", 40);
    expQ = '{32'hFFFF_FFFF, 32'd2};
    expShQ = '{32'd1, 32'd1};
    compareAll("mix");

    // Escape at prefix 14: code 14+5+2 = 21 -> -11
    loadStream({14'b0, 1'b1, 4'b0101, 109'b0});
    startBlock(1, 0);
    waitEnd("esc14", 40);
    expQ = '{32'hFFFF_FFF5};
    expShQ = '{32'd15, 32'd4};
    compareAll("esc14");

    // suffixLength adaptation: prefix 4 -> +4 raises suffixLength to 2,
    // then prefix 0 with 2 suffix bits '11' -> code 3 -> -2
    loadStream({5'b00001, 1'b1, 2'b11, 120'b0});
    startBlock(2, 0);
    waitEnd("adapt", 40);
    expQ = '{32'd4, 32'hFFFF_FFFE};
    expShQ = '{32'd1 + 32'd4, 32'd1, 32'd2};
    compareAll("adapt");

    // Prefix 15 with suffix 0xFFF: code 4127 -> -2064, narrowed to 8 bits
    loadStream({15'b0, 1'b1, 12'hFFF, 100'b0});
    startBlock(1, 0);
    waitEnd("p15", 40);
`ifdef CAVLC_LEVEL_SAT_EN
    expQ = '{32'hFFFF_FF81};
`else
    expQ = '{32'hFFFF_FFF0};
`endif
    expShQ = '{32'd16, 32'd12};
    compareAll("p15");

    // 16 leading zeros abort the block
    loadStream('0);
    startBlock(1, 0);
    waitEnd("zero16", 40);
    tick();
    check("zero16_nerr", 32'(errCnt), 32'd1);
    check("zero16_ndone", 32'(doneCnt), 32'd0);
    check("zero16_busy", 32'(Busy), 32'd0);
    compareAll("zero16");

    // Illegal starts
    loadStream('0);
    startBlock(1, 2);
    check("badt1_err", 32'(Error), 32'd1);
    check("badt1_busy", 32'(Busy), 32'd0);
    startBlock(17, 0);
    check("badtc_err", 32'(Error), 32'd1);
    check("badtc_busy", 32'(Busy), 32'd0);
    tick();
    check("bad_ndone", 32'(doneCnt), 32'd0);

    // suffixLength starts at 1 (TotalCoeff 11): "1","0" -> +2, held 5 cycles
    loadStream({2'b10, 126'b0});
    LevelReady = 1'b0;
    startBlock(11, 0);
    begin
      int n;
      n = 0;
      while (!WrReq && n < 10) begin
        tick();
        n++;
      end
    end
    check("bp_wrreq", 32'(WrReq), 32'd1);
    check("bp_level", 32'(LevelOut), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_wr%0d", i), 32'(WrReq), 32'd1);
      check($sformatf("bp_hold_lv%0d", i), 32'(LevelOut), 32'd2);
    end
    WinValid = 1'b0;
    LevelReady = 1'b1;
    tick();
    expQ = '{32'd2};
    expShQ = '{32'd1, 32'd1};
    compareAll("bp");
    check("bp_wr_low", 32'(WrReq), 32'd0);
    check("bp_busy", 32'(Busy), 32'd1);
    check("bp_stall_shen", 32'(ShiftEn), 32'd0);

    // Reset in PREFIX: everything returns to idle, no BlockDone
    tick();
    nReset = 1'b0;
    #1;
    checkIdleOutputs("midrst");
    tick();
    nReset = 1'b1;
    WinValid = 1'b1;
    tick();
    tick();
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_ndone", 32'(doneCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cavlc_level_dec.md
# cavlc_level_dec

Parametrised CAVLC coefficient-level decoder for H.264 4x4/2x2 residual blocks, the successor to the fixed 16-bit/13-bit CAVLC front end. It is started per block with TotalCoeff/TrailingOnes (from the coeff_token stage) and decodes trailing-one signs, level_prefix/level_suffix and the adaptive suffixLength. It then emits signed levels in bitstream order to a back-pressured level FIFO. Bits come from a peek window and are consumed through a shift request.

## Interface
- WIN_W, 16, bit-window width; must be >= 16.
- LEVEL_W, 13, signed level output width; must be >= 2.
- MAX_COEFF, 16, largest legal TotalCoeff (15 for AC, 4 for chroma DC); CW = $clog2(MAX_COEFF+1).
- Clk  in  1  clock.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle block start; ignored while Busy.
- TotalCoeff  in  CW  sampled on Start.
- TrailingOnes  in  2  sampled on Start.
- Window  in  WIN_W  next stream bits, MSB = next bit.
- WinValid  in  1  Window holds >= WIN_W valid bits.
- ShiftEn  out  1  consume ShiftBits this cycle.
- ShiftBits  out  $clog2(WIN_W+1)  bit count consumed, 1..16.
- LevelOut  out  LEVEL_W  signed level.
- WrReq  out  1  LevelOut valid.
- LevelReady  in  1  sink accepts; transfer = WrReq & LevelReady.
- BlockDone  out  1  one-cycle pulse, block complete.
- Error  out  1  one-cycle pulse, block aborted.
- Busy  out  1  not IDLE.

## Operation
- States: IDLE, T1, PREFIX, SUFFIX, OUT, DONE.
- On Start, validate the inputs. Error pulse, stay IDLE if TotalCoeff > MAX_COEFF or TrailingOnes > min(3, TotalCoeff).
- TotalCoeff == 0 goes to DONE. Otherwise init suffixLength = (TotalCoeff > 10 && TrailingOnes < 3) ? 1 : 0, idx = 0, and go to T1 if TrailingOnes > 0, else PREFIX.
- T1 (waits for WinValid): consume 1 bit; level = bit ? -1 : +1; go to OUT.
- PREFIX (waits for WinValid): prefix = leading zeros of Window[WIN_W-1 -: 16].
  - If all 16 bits are zero (prefix >= 16), pulse Error, go to IDLE, no BlockDone.
  - Otherwise consume prefix+1 bits.
  - sufSize = (prefix == 14 && suffixLength == 0) ? 4 : (prefix == 15) ? 12 : suffixLength.
  - If sufSize == 0, compute the level and go to OUT; else go to SUFFIX.
- SUFFIX (waits for WinValid): consume sufSize bits as unsigned level_suffix.
- levelCode arithmetic (14-bit unsigned) = (prefix << suffixLength) + level_suffix.
  - Add 15 if prefix == 15 && suffixLength == 0.
  - Add 2 if idx == TrailingOnes && TrailingOnes < 3.
  - level = even ? (levelCode+2)>>1 : -((levelCode+1)>>1), computed at 14 bits, then narrowed to LEVEL_W (see Configuration).
- suffixLength update, after each non-T1 level, in this order:
  - if 0, set to 1;
  - then, if |level| > (3 << (suffixLength-1)) and suffixLength < 6, increment.
  - Uses the full-width level, not the narrowed output.
- OUT: hold WrReq with LevelOut stable until transfer. Then idx++; if idx == TotalCoeff go to DONE, else go to T1 (idx < TrailingOnes) or PREFIX.
- DONE: BlockDone pulse, go to IDLE.
- ShiftEn is asserted only in T1/PREFIX/SUFFIX cycles with WinValid high, and never twice in the same cycle.
- Reset mid-block: immediate return to IDLE. Partial block discarded; no BlockDone.

## Timing
- Reset values: ShiftEn, ShiftBits, LevelOut, WrReq, BlockDone, Error and Busy all 0.
- All outputs are registered except ShiftEn/ShiftBits, which are combinational from state and Window. The source must apply the shift at the same clock edge.
- Start at edge n: Busy high from n+1; first consume at n+1 if WinValid.
- T1 level: WrReq 1 cycle after the consume. Non-T1 level: 1 cycle (sufSize 0) or 2 cycles after prefix consume.
- Minimum 2 cycles per level with LevelReady held high; +1 cycle when a suffix is read.
- BlockDone: the cycle after the last transfer; for TotalCoeff == 0, the cycle after Start.
- Start coincident with BlockDone is ignored.

## Configuration
- CAVLC_LEVEL_SAT_EN defined: levels outside ±(2^(LEVEL_W-1)-1) saturate to that bound.
- Undefined: level is truncated to the low LEVEL_W bits (two's-complement wrap).

## Test plan
- Reset and empty block:
  - Reset mid-PREFIX -> all outputs 0, IDLE.
  - Start with TotalCoeff=0 -> BlockDone next cycle, no WrReq, no ShiftEn.
- Trailing ones: TotalCoeff=3, TrailingOnes=3, bits 0,1,0 -> levels +1, -1, +1; three ShiftBits=1; BlockDone.
- Mixed block: TotalCoeff=2, TrailingOnes=1, bits "11" -> -1 then +2 (prefix 0, +2 bias).
- Escape at prefix 14: TotalCoeff=1, TrailingOnes=0, 14 zeros, 1, then 0101 -> ShiftBits 15 then 4; level -11.
- suffixLength init 1 and back-pressure: TotalCoeff=11, TrailingOnes=0, bits "10" -> level +2; LevelReady low 5 cycles -> WrReq/LevelOut stable throughout.
- Narrowing and errors with LEVEL_W=8:
  - prefix 15, suffix 0xFFF -> -127 with CAVLC_LEVEL_SAT_EN, -16 without.
  - 16 leading zeros -> Error, no BlockDone.
  - TrailingOnes=2 with TotalCoeff=1 -> Error.
